ahb_rr_arbiter: RTL and testbench

AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_rr_pick.sv | 32 +++
 rtl/ahb_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB protocol types shared by the arbiter slice: transfer, burst and
// response encodings, plus calc_beat() giving the fixed burst length.
package ahb_pkg;

    localparam int unsigned AHB_MAX_MASTERS = 16;
    localparam int unsigned BEAT_W          = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    // Beats in a fixed-length burst; 0 marks open-ended (SINGLE, INCR).
    function automatic logic [BEAT_W-1:0] calc_beat(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  calc_beat = BEAT_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  calc_beat = BEAT_W'(8);
            HBURST_WRAP16, HBURST_INCR16: calc_beat = BEAT_W'(16);
            default:                      calc_beat = '0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotating-priority search: returns the first set bit of req scanning
// upward from last+1 (wrapping), as a one-hot grant.
//   req   : candidate mask
//   last  : index of the previous owner (search starts just above it)
//   grant : one-hot winner, zero when no candidate
//   valid : a winner was found
module ahb_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [MW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = MW'((32'(last) + k) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with split masking, lock priority and
// default-master parking.
//   clk, rst          : clock, synchronous active-high reset
//   hbusreq, hlock    : per-master request / lock request
//   htrans, hburst    : control of the current transfer
//   hready, hresp     : slave handshake and response
//   hsplit            : per-master split-release strobes
//   hgrant            : registered one-hot grant
//   hmaster           : address-phase owner
//   hmastlock         : locked sequence in progress
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    if (NUM_MASTERS < 2 || NUM_MASTERS > AHB_MAX_MASTERS) begin : g_bad_param
        $error("ahb_rr_arbiter: NUM_MASTERS out of range");
    end

    logic [BEAT_W-1:0]      beat_cnt;
    logic [BEAT_W-1:0]      beat_len;
    logic [NUM_MASTERS-1:0] split_mask;
    logic                   split_d;
    logic [MW-1:0]          grant_idx;
    logic                   accept;
    logic                   fixed_last;
    logic                   arb_pt;
    logic                   split_first;
    logic [NUM_MASTERS-1:0] split_set;
    logic [NUM_MASTERS-1:0] mask_eff;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] grant_next;

    // Encode the current one-hot grant.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant[i]) grant_idx = MW'(i);
        end
    end

    // Arbitration point: idle, last fixed beat, or a non-OKAY response.
    always_comb begin
        beat_len   = calc_beat(hburst);
        accept     = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
        fixed_last = (beat_len != '0) && (htrans == HTRANS_SEQ)
                     && (beat_cnt == beat_len - BEAT_W'(1));
        arb_pt     = hready && (htrans == HTRANS_IDLE || fixed_last || hresp != HRESP_OKAY);
    end

    // Split mask: set on the first SPLIT cycle (not for a locked owner); release wins.
    always_comb begin
        split_first = (hresp == HRESP_SPLIT) && !split_d;
        split_set   = '0;
        if (split_first && !(hmastlock || hlock[hmaster])) split_set[hmaster] = 1'b1;
        mask_eff    = (split_mask | split_set) & ~hsplit;
    end

    ahb_rr_pick #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_pick (
        .req   (hbusreq & ~mask_eff),
        .last  (hmaster),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // A locked owner keeps the bus; otherwise round-robin, else park.
    always_comb begin
        grant_next = hgrant;
        if (arb_pt && !hlock[grant_idx]) begin
            grant_next = pick_valid ? pick_grant : DEF_GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hgrant     <= DEF_GRANT;
            hmaster    <= MW'(DEFAULT_MASTER);
            hmastlock  <= 1'b0;
            split_mask <= '0;
            split_d    <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            hgrant     <= grant_next;
            split_mask <= mask_eff;
            split_d    <= (hresp == HRESP_SPLIT);
            if (accept) begin
                beat_cnt <= (htrans == HTRANS_NONSEQ) ? BEAT_W'(1) : beat_cnt + BEAT_W'(1);
            end
            if (hready) begin
                hmaster <= grant_idx;
                if (hlock[grant_idx]) begin
                    hmastlock <= 1'b1;
                end else if (hmastlock && !hlock[hmaster]
                             && (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ)) begin
                    hmastlock <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter: reset, round-robin, INCR4 hold,
// split masking, lock, default park and reset mid-burst.
module tb_ahb_rr_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [1:0] R_OKAY   = 2'b00;
    localparam logic [1:0] R_RETRY  = 2'b10;
    localparam logic [1:0] R_SPLIT  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hbusreq, hlock, hsplit;
    logic [1:0] htrans, hresp;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    ahb_rr_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        hsplit  = 4'b0000;
        htrans  = T_IDLE;
        hburst  = B_SINGLE;
        hready  = 1'b1;
        hresp   = R_OKAY;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] rr_exp [5];

    initial begin
        rr_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        do_reset();
        chk("rst_hgrant", 32'(hgrant), 32'h1);
        chk("rst_hmaster", 32'(hmaster), 32'h0);
        chk("rst_hmastlock", 32'(hmastlock), 32'h0);
        chk("rst_mask", 32'(dut.split_mask), 32'h0);

        // Round-robin: SINGLE then IDLE with all requesting
        hbusreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            htrans = T_IDLE;
            tick();
            chk($sformatf("rr_hgrant_%0d", i), 32'(hgrant), 32'h1 << rr_exp[i]);
            htrans = T_NONSEQ;
            hburst = B_SINGLE;
            tick();
            chk($sformatf("rr_hmaster_%0d", i), 32'(hmaster), 32'(rr_exp[i]));
        end

        // INCR4 hold: master 2 owns, master 3 waits for the last beat
        do_reset();
        hbusreq = 4'b0100;
        tick();
        tick();
        chk("incr4_owner", 32'(hmaster), 32'h2);
        hbusreq = 4'b1100;
        hburst  = B_INCR4;
        htrans  = T_NONSEQ;
        tick();
        chk("incr4_nonseq", 32'(hgrant), 32'h4);
        htrans = T_SEQ;
        tick();
        chk("incr4_seq1", 32'(hgrant), 32'h4);
        tick();
        chk("incr4_seq2", 32'(hgrant), 32'h4);
        tick();
        chk("incr4_seq3", 32'(hgrant), 32'h8);
        htrans = T_IDLE;
        tick();
        chk("incr4_handover", 32'(hmaster), 32'h3);

        // Split masking of master 1 and release by hsplit[1]
        do_reset();
        hbusreq = 4'b0010;
        tick();
        tick();
        chk("split_owner", 32'(hmaster), 32'h1);
        hbusreq = 4'b0011;
        hready  = 1'b0;
        hresp   = R_SPLIT;
        tick();
        chk("split_mask_set", 32'(dut.split_mask), 32'h2);
        chk("split_hold", 32'(hgrant), 32'h2);
        hready = 1'b1;
        tick();
        chk("split_regrant", 32'(hgrant), 32'h1);
        hresp = R_OKAY;
        tick();
        tick();
        chk("split_skip", 32'(hgrant), 32'h1);
        hready = 1'b0;
        hsplit = 4'b0010;
        tick();
        chk("split_release", 32'(dut.split_mask), 32'h0);
        hsplit = 4'b0000;
        hready = 1'b1;
        tick();
        chk("split_reelig", 32'(hgrant), 32'h2);

        // Lock: master 0 holds across two INCR4 bursts, RETRY and SPLIT
        do_reset();
        hbusreq = 4'b1001;
        hlock   = 4'b0001;
        tick();
        chk("lock_set", 32'(hmastlock), 32'h1);
        chk("lock_grant", 32'(hgrant), 32'h1);
        hburst = B_INCR4;
        for (int b = 0; b < 8; b++) begin
            htrans = (b % 4 == 0) ? T_NONSEQ : T_SEQ;
            tick();
            chk($sformatf("lock_burst_grant_%0d", b), 32'(hgrant), 32'h1);
            chk($sformatf("lock_burst_mlock_%0d", b), 32'(hmastlock), 32'h1);
        end
        htrans = T_IDLE;
        hready = 1'b0;
        hresp  = R_RETRY;
        tick();
        hready = 1'b1;
        tick();
        chk("lock_retry", 32'(hgrant), 32'h1);
        hready = 1'b0;
        hresp  = R_SPLIT;
        tick();
        chk("lock_split_nomask", 32'(dut.split_mask), 32'h0);
        hready = 1'b1;
        tick();
        chk("lock_split_grant", 32'(hgrant), 32'h1);
        hresp = R_OKAY;
        hlock = 4'b0000;
        tick();
        chk("lock_clear", 32'(hmastlock), 32'h0);
        chk("lock_release", 32'(hgrant), 32'h8);

        // Default park: no requests, then sole requester split
        do_reset();
        hbusreq = 4'b0100;
        tick();
        tick();
        chk("park_owner", 32'(hgrant), 32'h4);
        hbusreq = 4'b0000;
        tick();
        chk("park_noreq", 32'(hgrant), 32'h1);
        hbusreq = 4'b0100;
        tick();
        tick();
        chk("park_owner2", 32'(hmaster), 32'h2);
        hready = 1'b0;
        hresp  = R_SPLIT;
        tick();
        chk("park_mask", 32'(dut.split_mask), 32'h4);
        hready = 1'b1;
        tick();
        chk("park_allsplit", 32'(hgrant), 32'h1);

        // Reset during the 2nd beat of an INCR8 with lock and mask live
        hresp   = R_OKAY;
        hbusreq = 4'b0010;
        hlock   = 4'b0010;
        tick();
        tick();
        chk("mid_pre_mlock", 32'(hmastlock), 32'h1);
        chk("mid_pre_owner", 32'(hmaster), 32'h1);
        chk("mid_pre_mask", 32'(dut.split_mask), 32'h4);
        hburst = B_INCR8;
        htrans = T_NONSEQ;
        tick();
        htrans = T_SEQ;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_hmaster", 32'(hmaster), 32'h0);
        chk("mid_hgrant", 32'(hgrant), 32'h1);
        chk("mid_hmastlock", 32'(hmastlock), 32'h0);
        chk("mid_mask", 32'(dut.split_mask), 32'h0);
        chk("mid_beat", 32'(dut.beat_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
